// File: rtl/verinject_injection_controller_if.sv
// Command and status bundle between the injection host and the injection controller.
// master = host / test harness side, slave = controller side.
interface verinject_injection_controller_if #(
  parameter int unsigned COUNT_WIDTH = 16
);
  logic                   cmd_valid;
  logic                   cmd_ready;
  logic [31:0]            cmd_bit_index;
  logic [31:0]            cmd_delay;
  logic [15:0]            cmd_duration;
  logic                   abort;
  logic [31:0]            verinject__injector_state;
  logic                   busy;
  logic                   done;
  logic                   aborted;
  logic                   cmd_error;
  logic [COUNT_WIDTH-1:0] injection_count;

  modport master (
    output cmd_valid, cmd_bit_index, cmd_delay, cmd_duration, abort,
    input  cmd_ready, verinject__injector_state, busy, done, aborted, cmd_error,
           injection_count
  );

  modport slave (
    input  cmd_valid, cmd_bit_index, cmd_delay, cmd_duration, abort,
    output cmd_ready, verinject__injector_state, busy, done, aborted, cmd_error,
           injection_count
  );
endinterface

// File: rtl/verinject_injection_controller.sv
// Sequences one fault-injection command at a time onto the shared injector-state bus:
// idle value while waiting, then the target bit index for exactly the commanded window.
module verinject_injection_controller #(
  parameter int unsigned NUM_BITS    = 1024,
  parameter logic [31:0] IDLE_STATE  = 32'hFFFF_FFFF,
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                              clock,
  input  logic                              reset,
  verinject_injection_controller_if.slave   bus_if
);

  localparam logic [31:0] NUM_BITS_W = 32'(NUM_BITS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_INJECT
  } state_t;

  state_t                 state_q;
  logic                   pend_q;
  logic                   ready_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   aborted_q;
  logic                   err_q;
  logic [31:0]            index_q;
  logic [31:0]            delay_q;
  logic [31:0]            bus_q;
  logic [15:0]            len_q;
  logic [15:0]            remain_q;
  logic [COUNT_WIDTH-1:0] count_q;

  logic                   take_d;
  logic                   idx_ok_d;
  logic [15:0]            len_d;

  assign take_d   = bus_if.cmd_valid && ready_q;
  assign idx_ok_d = (bus_if.cmd_bit_index < NUM_BITS_W);
  assign len_d    = (bus_if.cmd_duration == 16'd0) ? 16'd1 : bus_if.cmd_duration;

  // An accepted command spends one cycle latched (pend_q) in IDLE with cmd_ready low,
  // so busy and the bus window start on the edge after the handshake.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      pend_q    <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      err_q     <= 1'b0;
      index_q   <= 32'd0;
      delay_q   <= 32'd0;
      bus_q     <= IDLE_STATE;
      len_q     <= 16'd0;
      remain_q  <= 16'd0;
      count_q   <= '0;
    end else begin
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      err_q     <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (pend_q) begin
            pend_q <= 1'b0;
            busy_q <= 1'b1;
            if (delay_q == 32'd0) begin
              state_q  <= ST_INJECT;
              bus_q    <= index_q;
              remain_q <= len_q;
            end else begin
              state_q <= ST_WAIT;
            end
          end else if (take_d) begin
            if (idx_ok_d) begin
              pend_q  <= 1'b1;
              ready_q <= 1'b0;
              index_q <= bus_if.cmd_bit_index;
              delay_q <= bus_if.cmd_delay;
              len_q   <= len_d;
            end else begin
              err_q <= 1'b1;
            end
          end
        end

        ST_WAIT: begin
          if (bus_if.abort) begin
            state_q   <= ST_IDLE;
            bus_q     <= IDLE_STATE;
            busy_q    <= 1'b0;
            ready_q   <= 1'b1;
            aborted_q <= 1'b1;
          end else if (delay_q == 32'd1) begin
            state_q  <= ST_INJECT;
            bus_q    <= index_q;
            remain_q <= len_q;
          end else begin
            delay_q <= delay_q - 32'd1;
          end
        end

        ST_INJECT: begin
          // Abort wins over a completion falling on the same edge.
          if (bus_if.abort) begin
            state_q   <= ST_IDLE;
            bus_q     <= IDLE_STATE;
            busy_q    <= 1'b0;
            ready_q   <= 1'b1;
            aborted_q <= 1'b1;
          end else if (remain_q == 16'd1) begin
            state_q <= ST_IDLE;
            bus_q   <= IDLE_STATE;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b1;
            if (count_q != '1) begin
              count_q <= count_q + COUNT_WIDTH'(1);
            end
          end else begin
            remain_q <= remain_q - 16'd1;
          end
        end

        default: begin
          state_q <= ST_IDLE;
          bus_q   <= IDLE_STATE;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
          pend_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus_if.verinject__injector_state = bus_q;
  assign bus_if.cmd_ready                 = ready_q;
  assign bus_if.busy                      = busy_q;
  assign bus_if.done                      = done_q;
  assign bus_if.aborted                   = aborted_q;
  assign bus_if.cmd_error                 = err_q;
  assign bus_if.injection_count           = count_q;

  // The bus must only ever show the idle value or an in-range index.
  bus_legal_a: assert property (@(posedge clock) disable iff (reset)
    (bus_q == IDLE_STATE) || (bus_q < NUM_BITS_W));

  pulse_exclusive_a: assert property (@(posedge clock) disable iff (reset)
    !(done_q && aborted_q));

endmodule

// File: tb/tb_verinject_injection_controller.sv
// Directed, table-driven bench for the injection controller: per-cycle checks of the bus,
// handshake and status pulses, plus async reset and counter saturation sequences.
module tb_verinject_injection_controller;

  localparam int unsigned CW   = 8;
  localparam logic [31:0] IDLE = 32'hFFFF_FFFF;

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  verinject_injection_controller_if #(.COUNT_WIDTH(CW)) bus_if ();

  verinject_injection_controller #(
    .NUM_BITS    (1024),
    .IDLE_STATE  (IDLE),
    .COUNT_WIDTH (CW)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .bus_if (bus_if)
  );

  // abort_at: -1 none, 0 coincident with handshake, j>=2 sampled at edge k+j.
  // s/e: first bus cycle and done cycle relative to handshake edge k; cnt: count after.
  typedef struct {
    string       name;
    logic [31:0] idx;
    logic [31:0] dly;
    logic [15:0] dur;
    int          abort_at;
    int          s;
    int          e;
    bit          err;
    logic [7:0]  cnt;
  } vec_t;

  vec_t vecs[12];
  int   tests = 0;
  int   fails = 0;

  function automatic logic [63:0] pack(logic [31:0] b, logic rdy, logic bsy, logic dn,
                                       logic ab, logic er, logic [7:0] c);
    return {19'd0, b, rdy, bsy, dn, ab, er, c};
  endfunction

  function automatic logic [63:0] obs();
    return pack(bus_if.verinject__injector_state, bus_if.cmd_ready, bus_if.busy,
                bus_if.done, bus_if.aborted, bus_if.cmd_error, bus_if.injection_count);
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (bus|rdy|busy|done|abrt|err|cnt)", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    vec_t        cur;
    logic [7:0]  prev_cnt;
    int          last;
    int          stop;
    bit          aborts;
    logic [63:0] exp;
    int          ndone;
    int          guard;
    logic [7:0]  cnt_at10;

    vecs[0]  = '{"d0_l1",        32'd5,         32'd0,  16'd1, -1, 1,  2,  1'b0, 8'd1};
    vecs[1]  = '{"d3_l4",        32'd1023,      32'd3,  16'd4, -1, 4,  8,  1'b0, 8'd2};
    vecs[2]  = '{"d3_dur0",      32'd1023,      32'd3,  16'd0, -1, 4,  5,  1'b0, 8'd3};
    vecs[3]  = '{"oob_1024",     32'd1024,      32'd0,  16'd1, -1, 0,  0,  1'b1, 8'd3};
    vecs[4]  = '{"after_err",    32'd7,         32'd0,  16'd1, -1, 1,  2,  1'b0, 8'd4};
    vecs[5]  = '{"abort_wait",   32'd100,       32'd10, 16'd3,  5, 11, 14, 1'b0, 8'd4};
    vecs[6]  = '{"abort_inject", 32'd200,       32'd0,  16'd5,  3, 1,  6,  1'b0, 8'd4};
    vecs[7]  = '{"abort_final",  32'd300,       32'd2,  16'd3,  6, 3,  6,  1'b0, 8'd4};
    vecs[8]  = '{"idle_abort",   32'd42,        32'd0,  16'd2,  0, 1,  3,  1'b0, 8'd5};
    vecs[9]  = '{"idx0_d1_l2",   32'd0,         32'd1,  16'd2, -1, 2,  4,  1'b0, 8'd6};
    vecs[10] = '{"oob_max",      32'hFFFF_FFFF, 32'd5,  16'd5, -1, 0,  0,  1'b1, 8'd6};
    vecs[11] = '{"d0_l3_1023",   32'd1023,      32'd0,  16'd3, -1, 1,  4,  1'b0, 8'd7};

    bus_if.cmd_valid     = 1'b0;
    bus_if.cmd_bit_index = 32'd0;
    bus_if.cmd_delay     = 32'd0;
    bus_if.cmd_duration  = 16'd0;
    bus_if.abort         = 1'b0;

    repeat (3) @(negedge clock);
    check("reset_state", obs(), pack(IDLE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0));
    reset = 1'b0;

    for (int i = 0; i < 20; i++) begin
      cycle();
      check("idle_quiet", obs(), pack(IDLE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0));
    end

    prev_cnt = 8'd0;
    for (int v = 0; v < 12; v++) begin
      cur = vecs[v];
      bus_if.cmd_bit_index = cur.idx;
      bus_if.cmd_delay     = cur.dly;
      bus_if.cmd_duration  = cur.dur;
      bus_if.cmd_valid     = 1'b1;
      bus_if.abort         = (cur.abort_at == 0);
      cycle();
      bus_if.cmd_valid = 1'b0;
      bus_if.abort     = 1'b0;
      check({cur.name, "_accept"}, obs(),
            pack(IDLE, cur.err, 1'b0, 1'b0, 1'b0, cur.err, prev_cnt));
      $display("[TB] cmd %s idx=%0d delay=%0d dur=%0d", cur.name, cur.idx, cur.dly, cur.dur);

      aborts = (cur.abort_at >= 2) && (cur.abort_at <= cur.e);
      stop   = aborts ? cur.abort_at : cur.e;
      last   = cur.err ? 0 : cur.e + 2;
      for (int j = 1; j <= last; j++) begin
        bus_if.abort = (cur.abort_at == j);
        cycle();
        bus_if.abort = 1'b0;
        exp = pack((j >= cur.s && j < stop) ? cur.idx : IDLE,
                   j >= stop, j < stop,
                   !aborts && (j == cur.e),
                   aborts && (j == stop),
                   1'b0,
                   (j >= stop) ? cur.cnt : prev_cnt);
        check($sformatf("%s_c%0d", cur.name, j), obs(), exp);
      end
      prev_cnt = cur.cnt;
    end

    // Asynchronous reset in the middle of an injection window.
    bus_if.cmd_bit_index = 32'd9;
    bus_if.cmd_delay     = 32'd0;
    bus_if.cmd_duration  = 16'd10;
    bus_if.cmd_valid     = 1'b1;
    cycle();
    bus_if.cmd_valid = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("pre_reset_inject", obs(), pack(32'd9, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd7));
    #1 reset = 1'b1;
    #1;
    check("async_reset", obs(), pack(IDLE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0));
    @(negedge clock);
    reset = 1'b0;
    cycle();
    check("post_reset", obs(), pack(IDLE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0));

    // Back-to-back commands until the counter saturates.
    bus_if.cmd_bit_index = 32'd5;
    bus_if.cmd_delay     = 32'd0;
    bus_if.cmd_duration  = 16'd1;
    bus_if.cmd_valid     = 1'b1;
    ndone    = 0;
    guard    = 0;
    cnt_at10 = 8'd0;
    while (ndone < 260 && guard < 2000) begin
      cycle();
      guard++;
      if (bus_if.done === 1'b1) begin
        ndone++;
        if (ndone == 10) cnt_at10 = bus_if.injection_count;
      end
    end
    bus_if.cmd_valid = 1'b0;
    check("sat_done_pulses", 64'(ndone), 64'd260);
    check("count_at_10", {56'd0, cnt_at10}, 64'd10);
    repeat (3) cycle();
    check("count_saturated", obs(), pack(IDLE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF));
    $display("[TB] saturation: %0d done pulses in %0d cycles", ndone, guard);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/verinject_injection_controller.md
# verinject_injection_controller

Sequencer that drives the shared `verinject__injector_state` bus read by every FF/memory fault injector in an instrumented design. Accepts one injection command at a time (global target bit index, delay in clock cycles, duration), holds the bus at an idle value that matches no injector, then presents the target index for exactly the commanded number of cycles. Sits at the top of the instrumented hierarchy, between the test harness or host command interface and the injector network.

## Interface
- `NUM_BITS`, 1024: number of injectable bits in the design. Valid indices are 0..NUM_BITS-1.
- `IDLE_STATE`, 32'hFFFF_FFFF: bus value when no injection is active. Must be >= NUM_BITS; this is a configuration requirement and is not checked in RTL.
- `COUNT_WIDTH`, 16: width of the completed-injection counter.
- `clock`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  high only in IDLE; a command is accepted on a rising edge where `cmd_valid && cmd_ready`.
- `cmd_bit_index`  in  32  global target bit index.
- `cmd_delay`  in  32  cycles to wait before the injection window starts.
- `cmd_duration`  in  16  injection window length in cycles; 0 is treated as 1.
- `abort`  in  1  cancels a pending or active injection.
- `verinject__injector_state`  out  32  registered bus to all injectors.
- `busy`  out  1  high in WAIT or INJECT.
- `done`  out  1  one-cycle pulse when an injection window completes normally.
- `aborted`  out  1  one-cycle pulse when `abort` cancels WAIT or INJECT.
- `cmd_error`  out  1  one-cycle pulse when an accepted command is rejected for an out-of-range index.
- `injection_count`  out  COUNT_WIDTH  completed injections; saturates at all-ones.

## Operation
- Reset values: FSM=IDLE, `verinject__injector_state`=IDLE_STATE, `cmd_ready`=1, `busy`=0, `done`=0, `aborted`=0, `cmd_error`=0, `injection_count`=0. Internal counters clear to 0.
- FSM states: IDLE, WAIT, INJECT.
- **IDLE**
  - On handshake with `cmd_bit_index >= NUM_BITS`: stay in IDLE and pulse `cmd_error` on the next cycle.
  - On handshake with a valid index: latch index and L = max(`cmd_duration`, 1).
  - If `cmd_delay`=0, go to INJECT. Otherwise go to WAIT with the delay counter set to `cmd_delay`.
- **WAIT**
  - Decrement the delay counter each cycle.
  - When the counter is 1, the next state is INJECT.
  - The bus stays at IDLE_STATE.
- **INJECT**
  - The bus equals the latched index.
  - The remaining counter is loaded with L on entry and decrements each cycle.
  - On the cycle the remaining counter is 1: next state is IDLE, the bus returns to IDLE_STATE, `done` pulses, and `injection_count` increments, saturating at all-ones.
- **abort**
  - In WAIT or INJECT: next state is IDLE, the bus returns to IDLE_STATE, `aborted` pulses, there is no `done` pulse, and the count is unchanged.
  - Abort takes priority over completion in the same cycle.
  - In IDLE, `abort` is ignored, and a coincident command is accepted normally.
- The bus never carries any value other than IDLE_STATE or a latched valid index.

## Timing
- Handshake at edge k.
  - The bus equals the index from edge k+1+D through edge k+1+D+L, exclusive.
  - That is exactly L cycles of assertion, where D = `cmd_delay`.
- At edge k+1+D+L: the bus returns to IDLE_STATE, `done`=1 for one cycle, `cmd_ready`=1.
  - The earliest next handshake is at edge k+2+D+L.
- `busy` is high from edge k+1 until edge k+1+D+L.
- Rejected command at edge k: `cmd_error` is high for the cycle after edge k. `cmd_ready` stays high.
- Abort sampled at edge m while busy: the bus is IDLE_STATE and `aborted`=1 after edge m.
- Asynchronous `reset` mid-operation forces all outputs to their reset values immediately, without waiting for a clock edge.
- Because injectors are combinational on the bus, each cycle the bus holds an index flips that bit in whatever the targeted register captures at the following edge.

## Test plan
- After reset, with no command: the bus = 32'hFFFF_FFFF, `cmd_ready`=1, and all pulses are 0 for 20 cycles.
- Command index=5, delay=0, duration=1 accepted at edge k:
  - The bus = 5 for exactly the cycle after edge k+1.
  - `done` pulses after edge k+2.
  - `injection_count`=1.
- Command index=1023, delay=3, duration=4:
  - The bus is idle for 3 cycles, then 1023 for 4 cycles.
  - `busy` is high for 7 cycles, then one `done` pulse.
  - Duration=0 variant gives exactly one cycle at the index.
- Command index=1024 with NUM_BITS=1024: one `cmd_error` pulse, the bus stays idle, the count is unchanged, and a next valid command is accepted immediately.
- Abort cases, each producing one `aborted` pulse, no `done`, and count unchanged:
  - Abort during WAIT (delay=10, abort at cycle 4).
  - Abort during INJECT (duration=5, abort at cycle 2): the bus goes idle next edge.
  - Abort coincident with the final INJECT cycle.
- Assert `reset` asynchronously mid-INJECT: the bus is idle immediately, and the count clears to 0.
- Issue 65536 back-to-back commands: `injection_count` saturates at 16'hFFFF.
